// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with a 2-entry skid buffer, flush and bubble output.
// Optional perf counters (stall_cnt, bubble_cnt) enabled by defining PIPE_PERF_CNT_EN.
module pipe_stage_reg #(
  parameter int          DATA_W = 64,
  parameter logic [63:0] BUBBLE = 64'h13,
  parameter int          CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  localparam logic [DATA_W-1:0] BUBBLE_V = DATA_W'(BUBBLE);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              load_main_in, load_main_skid, load_skid;
  logic              in_fire, out_fire;

  // Flags depend only on the state register, so in_ready never sees out_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign out_data  = out_valid ? main_q : BUBBLE_V;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_nxt    = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          load_main_skid = 1'b1;
          state_nxt      = BUSY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // A flush discards any handshake in the same cycle.
    if (flush) begin
      state_nxt      = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= BUBBLE_V;
      skid_q <= BUBBLE_V;
    end else begin
      state <= state_nxt;
      if (load_main_in)   main_q <= in_data;
      if (load_main_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= in_data;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Counters saturate and survive flush; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (!out_valid && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
